counter_sequencer: RTL and testbench

- Run controller for one counter_modulo instance.
- Drives the counter's ce and rst inputs and uses its out value as feedback.
- Runs the counter for a programmed number of full modulo periods, with a prescaler between clk and ce.
- Supports pause and abort; signals completion to the host FSM with a single-cycle done pulse.

---
 rtl/counter_sequencer.sv | 71 +++++++
 tb/tb_counter_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: prescaled multi-period run controller for a modulo counter
module counter_sequencer #(
  parameter int MODULO    = 4,
  parameter int WIDTH     = $clog2(MODULO),
  parameter int PRESCALE  = 10,
  parameter int PS_WIDTH  = ($clog2(PRESCALE) > 0 ? $clog2(PRESCALE) : 1),
  parameter int CYC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 abort,
  input  logic [CYC_WIDTH-1:0] num_wraps,
  input  logic [WIDTH-1:0]     cnt_val,
  output logic                 cnt_ce,
  output logic                 cnt_rst,
  output logic                 busy,
  output logic                 done,
  output logic [CYC_WIDTH-1:0] wraps_left
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [PS_WIDTH-1:0] ps, ps_n;
  logic [CYC_WIDTH-1:0] wl_n;
  logic wrap;
  assign cnt_ce  = (state == RUN) && (ps == PS_WIDTH'(PRESCALE - 1)) && !pause;
  assign cnt_rst = state == CLEAR;
  assign busy    = (state == CLEAR) || (state == RUN) || (state == HOLD);
  assign done    = state == DONE;
  assign wrap    = cnt_ce && (cnt_val == WIDTH'(MODULO - 1));
  always_comb begin
    state_n = state;
    ps_n    = ps;
    wl_n    = wraps_left;
    if (abort && busy) begin
      state_n = IDLE;
      wl_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = start ? (num_wraps != '0 ? CLEAR : DONE) : IDLE;
          wl_n    = start ? num_wraps : wraps_left;
        end
        CLEAR: begin
          state_n = pause ? HOLD : RUN;
          ps_n    = '0;
        end
        RUN: begin
          state_n = pause ? HOLD : (wrap && wraps_left == CYC_WIDTH'(1)) ? DONE : RUN;
          ps_n    = pause ? ps : (ps == PS_WIDTH'(PRESCALE - 1)) ? '0 : ps + 1'b1;
          wl_n    = wrap ? wraps_left - 1'b1 : wraps_left;
        end
        HOLD:    state_n = pause ? HOLD : RUN;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ps         <= '0;
      wraps_left <= '0;
    end else begin
      state      <= state_n;
      ps         <= ps_n;
      wraps_left <= wl_n;
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: table-driven scoreboard bench for counter_sequencer
module tb_counter_sequencer;
  typedef struct {
    int u, nw, p_at, p_len, a_at, s_mid;
    int ce, rs, bz, dn, en, fst, wl1;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, pause = 0, abort = 0;
  logic [7:0] num_wraps = '0;
  logic [1:0] v0 = '0;
  logic [0:0] v1 = '0;
  logic ce0, rs0, bz0, dn0, ce1, rs1, bz1, dn1;
  logic [7:0] wl0, wl1;
  int n_cmp = 0, n_err = 0;
  vec_t sb[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  counter_sequencer #(.MODULO(4), .PRESCALE(3)) d0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .num_wraps(num_wraps), .cnt_val(v0), .cnt_ce(ce0), .cnt_rst(rs0),
    .busy(bz0), .done(dn0), .wraps_left(wl0)
  );
  counter_sequencer #(.MODULO(2), .PRESCALE(1)) d1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .num_wraps(num_wraps), .cnt_val(v1), .cnt_ce(ce1), .cnt_rst(rs1),
    .busy(bz1), .done(dn1), .wraps_left(wl1)
  );
  always_ff @(posedge clk) begin
    v0 <= (rst || rs0) ? 2'd0 : ce0 ? v0 + 2'd1 : v0;
    v1 <= (rst || rs1) ? 1'b0 : ce1 ? v1 + 1'b1 : v1;
  end
  task automatic chk(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((bz0 || dn0 || bz1 || dn1) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("idle_timeout", 1, 0);
    tick();
  endtask
  task automatic run(input int idx, input vec_t v);
    int ces = 0, rss = 0, bzs = 0, dnc = 0, en = 0, fst = 0, w1 = -1, pl = 0;
    bit apend = 0;
    logic c, r, b, d;
    int w;
    vec_t e;
    sb.push_back(v);
    start = 1;
    num_wraps = 8'(v.nw);
    for (int n = 1; n <= 200; n++) begin
      tick();
      start = (n == v.s_mid);
      num_wraps = 8'hA5;
      pause = pl > 0;
      if (pl > 0) pl--;
      abort = apend;
      apend = 0;
      #1;
      c = v.u != 0 ? ce1 : ce0;
      r = v.u != 0 ? rs1 : rs0;
      b = v.u != 0 ? bz1 : bz0;
      d = v.u != 0 ? dn1 : dn0;
      w = v.u != 0 ? int'(wl1) : int'(wl0);
      if (n == 1) w1 = w;
      if (c) begin
        ces++;
        if (fst == 0) fst = n;
        if (v.p_at != 0 && ces == v.p_at) pl = v.p_len;
        if (v.a_at != 0 && ces == v.a_at) apend = 1;
      end
      if (r) rss++;
      if (b) bzs++;
      if (d) begin
        dnc = n;
        en = n;
        break;
      end
      if (n > 1 && !b) begin
        en = n;
        break;
      end
    end
    start = 0;
    pause = 0;
    abort = 0;
    w = v.u != 0 ? int'(wl1) : int'(wl0);
    if (en == 0) chk($sformatf("c%0d_timeout", idx), 1, 0);
    e = sb.pop_front();
    chk($sformatf("c%0d_ce_count", idx), ces, e.ce);
    chk($sformatf("c%0d_rst_cycles", idx), rss, e.rs);
    chk($sformatf("c%0d_busy_cycles", idx), bzs, e.bz);
    chk($sformatf("c%0d_done_cycle", idx), dnc, e.dn);
    chk($sformatf("c%0d_end_cycle", idx), en, e.en);
    chk($sformatf("c%0d_first_ce", idx), fst, e.fst);
    chk($sformatf("c%0d_wl_latched", idx), w1, e.wl1);
    chk($sformatf("c%0d_wl_end", idx), w, 0);
  endtask
  initial begin
    int cnt;
    tbl[0] = '{0, 2, 0, 0, 0, 0,  8, 1, 25, 26, 26, 4, 2};
    tbl[1] = '{0, 2, 3, 5, 0, 0,  8, 1, 31, 32, 32, 4, 2};
    tbl[2] = '{0, 2, 0, 0, 5, 0,  5, 1, 17,  0, 18, 4, 2};
    tbl[3] = '{0, 1, 0, 0, 0, 0,  4, 1, 13, 14, 14, 4, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0,  0, 0,  0,  1,  1, 0, 0};
    tbl[5] = '{1, 3, 0, 0, 0, 4,  6, 1,  7,  8,  8, 2, 3};
    tbl[6] = '{0, 3, 0, 0, 0, 5, 12, 1, 37, 38, 38, 4, 3};
    repeat (3) tick();
    chk("reset_ce", int'(ce0), 0);
    chk("reset_cnt_rst", int'(rs0), 0);
    chk("reset_busy", int'(bz0), 0);
    chk("reset_done", int'(dn0), 0);
    chk("reset_wl", int'(wl0), 0);
    chk("reset_busy_d1", int'(bz1), 0);
    rst = 0;
    tick();
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      run(i, tbl[i]);
    end
    wait_idle();
    start = 1;
    num_wraps = 8'd2;
    tick();
    start = 0;
    repeat (9) tick();
    chk("mid_busy_before_rst", int'(bz0), 1);
    rst = 1;
    abort = 1;
    start = 1;
    tick();
    rst = 0;
    abort = 0;
    start = 0;
    #1;
    chk("rst_ce", int'(ce0), 0);
    chk("rst_cnt_rst", int'(rs0), 0);
    chk("rst_busy", int'(bz0), 0);
    chk("rst_done", int'(dn0), 0);
    chk("rst_wl", int'(wl0), 0);
    chk("rst_busy_d1", int'(bz1), 0);
    cnt = 0;
    repeat (30) begin
      tick();
      if (dn0 || bz0 || dn1 || bz1) cnt++;
    end
    chk("rst_no_activity", cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
